garota_reset_ctrl: RTL and testbench

- Downstream consumer of the GAROTA violation-reset request.
- Registers the seven per-monitor violation lines, turns any violation into a fixed-length, glitch-free CPU reset pulse, then enforces a short quiet window.
- Keeps a sticky cause register and a saturating violation counter on the openMSP430 peripheral bus, so TCB code can read the reset cause after reboot.
- A cause write (W1C) takes effect only while pc is inside the TCB.

---
 rtl/garota_pkg.sv | 14 +
 rtl/garota_reset_ctrl_reg_if.sv | 33 +++
 rtl/garota_reset_ctrl.sv | 91 +++++++++
 tb/tb_garota_reset_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/garota_pkg.sv
// garota_pkg: shared constants for the GAROTA violation-reset controller
package garota_pkg;
  localparam int VIOL_W        = 7;
  localparam int VIOL_PMEM     = 0;
  localparam int VIOL_UART     = 1;
  localparam int VIOL_INTR     = 2;
  localparam int VIOL_P1       = 3;
  localparam int VIOL_ATOMIC   = 4;
  localparam int VIOL_IRQ_TCB  = 5;
  localparam int VIOL_IRQ_DIS  = 6;
  localparam logic [13:0] REG_CAUSE = 14'd0;
  localparam logic [13:0] REG_COUNT = 14'd1;
  typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, QUIET = 2'd2} state_e;
endpackage

// File: rtl/garota_reset_ctrl_reg_if.sv
// garota_reset_ctrl_reg_if: register decode, TCB-gated W1C of CAUSE, read mux
//   per_*_i   : openMSP430 peripheral bus inputs
//   pc_i      : program counter, gates CAUSE clears to the TCB region
//   cause_i   : current CAUSE bits; count_i : current COUNT
//   per_dout_o: read data (0 unless a mapped read); clr_o: bits to clear
module garota_reset_ctrl_reg_if
  import garota_pkg::*;
#(
  parameter logic [14:0] BASE_ADDR = 15'h0190,
  parameter logic [15:0] TCB_BASE  = 16'hFAE0,
  parameter logic [15:0] TCB_SIZE  = 16'h03FC
)(
  input  logic [13:0]       per_addr_i,
  input  logic [15:0]       per_din_i,
  input  logic              per_en_i,
  input  logic [1:0]        per_we_i,
  input  logic [15:0]       pc_i,
  input  logic [VIOL_W-1:0] cause_i,
  input  logic [15:0]       count_i,
  output logic [15:0]       per_dout_o,
  output logic [VIOL_W-1:0] clr_o
);
  localparam logic [13:0] BASE_W  = BASE_ADDR[14:1];
  localparam logic [16:0] TCB_END = {1'b0, TCB_BASE} + {1'b0, TCB_SIZE};
  logic sel_cause, sel_count, rd, in_tcb, unused_din;
  assign sel_cause  = per_en_i && (per_addr_i == BASE_W + REG_CAUSE);
  assign sel_count  = per_en_i && (per_addr_i == BASE_W + REG_COUNT);
  assign rd         = ~|per_we_i;
  assign in_tcb     = (pc_i >= TCB_BASE) && ({1'b0, pc_i} <= TCB_END);
  assign per_dout_o = !rd ? 16'd0 : sel_cause ? {9'd0, cause_i} : sel_count ? count_i : 16'd0;
  assign clr_o      = (sel_cause && per_we_i[0] && in_tcb) ? per_din_i[VIOL_W-1:0] : '0;
  assign unused_din = ^per_din_i[15:VIOL_W];
endmodule

// File: rtl/garota_reset_ctrl.sv
// garota_reset_ctrl: turns GAROTA violations into a fixed-length CPU reset pulse
//   clk, reset_n : clock, synchronous active-low reset
//   viol         : per-monitor violation lines
//   pc           : program counter (gates CAUSE clears)
//   per_*        : openMSP430 peripheral bus (CAUSE at BASE_ADDR, COUNT at +2)
//   cpu_rst      : registered PUC request, high HOLD_CYCLES cycles per trigger
//   cause_valid  : CAUSE is nonzero
module garota_reset_ctrl
  import garota_pkg::*;
#(
  parameter logic [14:0] BASE_ADDR    = 15'h0190,
  parameter logic [15:0] TCB_BASE     = 16'hFAE0,
  parameter logic [15:0] TCB_SIZE     = 16'h03FC,
  parameter int unsigned HOLD_CYCLES  = 8,
  parameter int unsigned QUIET_CYCLES = 2
)(
  input  logic              clk,
  input  logic              reset_n,
  input  logic [VIOL_W-1:0] viol,
  input  logic [15:0]       pc,
  input  logic [13:0]       per_addr,
  input  logic [15:0]       per_din,
  input  logic              per_en,
  input  logic [1:0]        per_we,
  output logic [15:0]       per_dout,
  output logic              cpu_rst,
  output logic              cause_valid
);
  localparam logic [7:0] HOLD_INIT  = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] QUIET_INIT = 8'((QUIET_CYCLES == 0) ? 0 : QUIET_CYCLES - 1);
  state_e            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [VIOL_W-1:0] cause_q, cause_d, clr;
  logic [15:0]       count_q, count_d;
  logic              cpu_rst_q, cause_valid_q, trigger;
  garota_reset_ctrl_reg_if #(
    .BASE_ADDR(BASE_ADDR),
    .TCB_BASE (TCB_BASE),
    .TCB_SIZE (TCB_SIZE)
  ) u_reg_if (
    .per_addr_i(per_addr),
    .per_din_i (per_din),
    .per_en_i  (per_en),
    .per_we_i  (per_we),
    .pc_i      (pc),
    .cause_i   (cause_q),
    .count_i   (count_q),
    .per_dout_o(per_dout),
    .clr_o     (clr)
  );
  assign trigger = (state_q == IDLE) && |viol;
  // set beats clear; violations in the quiet window are neither recorded nor counted
  assign cause_d = (cause_q & ~clr) | ((state_q == QUIET) ? '0 : viol);
  assign count_d = (trigger && count_q != 16'hFFFF) ? count_q + 16'd1 : count_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (trigger) begin
        state_d = HOLD;
        cnt_d   = HOLD_INIT;
      end
      HOLD: if (cnt_q == 8'd0) begin
        state_d = (QUIET_CYCLES == 0) ? IDLE : QUIET;
        cnt_d   = QUIET_INIT;
      end else cnt_d = cnt_q - 8'd1;
      QUIET: if (cnt_q == 8'd0) state_d = IDLE;
             else cnt_d = cnt_q - 8'd1;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      cause_q       <= '0;
      count_q       <= '0;
      cpu_rst_q     <= 1'b0;
      cause_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cause_q       <= cause_d;
      count_q       <= count_d;
      cpu_rst_q     <= (state_d == HOLD);
      cause_valid_q <= |cause_d;
    end
  end
  assign cpu_rst     = cpu_rst_q;
  assign cause_valid = cause_valid_q;
endmodule

// File: tb/tb_garota_reset_ctrl.sv
// tb_garota_reset_ctrl: directed checks of pulse, masking, W1C gating, saturation, reset
module tb_garota_reset_ctrl;
  import garota_pkg::*;
  localparam logic [13:0] A_CAUSE = 14'h00C8;
  localparam logic [13:0] A_COUNT = 14'h00C9;
  logic clk = 1'b0, reset_n = 1'b0;
  logic [6:0] viol = '0, s_viol = '0;
  logic [15:0] pc = 16'h0000, per_din = '0;
  logic [13:0] per_addr = '0;
  logic per_en = 1'b0;
  logic [1:0] per_we = '0;
  logic [15:0] per_dout, s_dout;
  logic cpu_rst, cause_valid, s_rst, s_valid;
  int vectors = 0, miscompares = 0;
  logic [15:0] d, ds;
  int highs;
  always #5 clk = ~clk;
  garota_reset_ctrl dut (
    .clk(clk), .reset_n(reset_n), .viol(viol), .pc(pc), .per_addr(per_addr),
    .per_din(per_din), .per_en(per_en), .per_we(per_we), .per_dout(per_dout),
    .cpu_rst(cpu_rst), .cause_valid(cause_valid)
  );
  garota_reset_ctrl #(.HOLD_CYCLES(1), .QUIET_CYCLES(0)) dut_s (
    .clk(clk), .reset_n(reset_n), .viol(s_viol), .pc(pc), .per_addr(per_addr),
    .per_din(per_din), .per_en(per_en), .per_we(per_we), .per_dout(s_dout),
    .cpu_rst(s_rst), .cause_valid(s_valid)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic rd(input logic [13:0] a, output logic [15:0] dv, output logic [15:0] dsv);
    per_addr = a;
    per_we   = 2'b00;
    per_en   = 1'b1;
    #1;
    dv  = per_dout;
    dsv = s_dout;
    per_en   = 1'b0;
    per_addr = '0;
  endtask
  task automatic wr(input logic [13:0] a, input logic [1:0] we, input logic [15:0] din);
    per_addr = a;
    per_we   = we;
    per_din  = din;
    per_en   = 1'b1;
    tick();
    per_en = 1'b0;
    per_we = '0;
    per_din = '0;
  endtask
  task automatic run(input int n, output int h);
    h = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (cpu_rst) h++;
    end
  endtask
  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask
  initial begin
    do_reset();
    chk("rst_cpu_rst", cpu_rst, 0);
    chk("rst_valid", cause_valid, 0);
    rd(A_CAUSE, d, ds); chk("rst_cause", d, 16'h0000);
    rd(A_COUNT, d, ds); chk("rst_count", d, 16'h0000);
    // single pulse
    viol = 7'h01;
    chk("pre_trig_rst", cpu_rst, 0);
    tick();
    chk("trig_latency", cpu_rst, 1);
    viol = 7'h00;
    run(11, highs);
    chk("pulse_len", highs + 1, 8);
    chk("pulse_end", cpu_rst, 0);
    rd(A_CAUSE, d, ds); chk("single_cause", d, 16'h0001);
    rd(A_COUNT, d, ds); chk("single_count", d, 16'h0001);
    chk("single_valid", cause_valid, 1);
    // burst during HOLD
    do_reset();
    viol = 7'h10;
    tick();
    viol = 7'h00;
    run(2, highs);
    viol = 7'h40;
    tick();
    if (cpu_rst) highs++;
    viol = 7'h00;
    run(12, d);
    chk("burst_len", highs + d + 1, 8);
    rd(A_CAUSE, d, ds); chk("burst_cause", d, 16'h0050);
    rd(A_COUNT, d, ds); chk("burst_count", d, 16'h0001);
    // quiet masking
    do_reset();
    viol = 7'h01;
    tick();
    viol = 7'h00;
    run(8, highs);
    chk("quiet_hold_len", highs + 1, 8);
    viol = 7'h02;
    tick();
    chk("quiet_no_rst1", cpu_rst, 0);
    tick();
    chk("quiet_no_rst2", cpu_rst, 0);
    rd(A_CAUSE, d, ds); chk("quiet_cause", d, 16'h0001);
    rd(A_COUNT, d, ds); chk("quiet_count", d, 16'h0001);
    tick();
    chk("idle_retrig", cpu_rst, 1);
    viol = 7'h00;
    rd(A_COUNT, d, ds); chk("retrig_count", d, 16'h0002);
    rd(A_CAUSE, d, ds); chk("retrig_cause", d, 16'h0003);
    run(12, highs);
    // W1C gating
    pc = 16'hE100;
    wr(A_CAUSE, 2'b01, 16'h0001);
    rd(A_CAUSE, d, ds); chk("w1c_outside", d, 16'h0003);
    pc = 16'hFB00;
    per_addr = A_CAUSE; per_we = 2'b01; per_din = 16'h0001; per_en = 1'b1;
    #1;
    chk("dout_during_write", per_dout, 16'h0000);
    tick();
    per_en = 1'b0; per_we = '0; per_din = '0;
    rd(A_CAUSE, d, ds); chk("w1c_inside", d, 16'h0002);
    viol = 7'h01;
    wr(A_CAUSE, 2'b01, 16'h0001);
    viol = 7'h00;
    rd(A_CAUSE, d, ds); chk("w1c_set_wins", d, 16'h0003);
    run(12, highs);
    pc = 16'hFEDD;
    wr(A_CAUSE, 2'b01, 16'h0002);
    rd(A_CAUSE, d, ds); chk("w1c_past_end", d, 16'h0003);
    pc = 16'hFADF;
    wr(A_CAUSE, 2'b01, 16'h0002);
    rd(A_CAUSE, d, ds); chk("w1c_below_base", d, 16'h0003);
    pc = 16'hFEDC;
    wr(A_CAUSE, 2'b10, 16'h0002);
    rd(A_CAUSE, d, ds); chk("w1c_hi_byte_only", d, 16'h0003);
    wr(A_CAUSE, 2'b01, 16'h0002);
    rd(A_CAUSE, d, ds); chk("w1c_at_end", d, 16'h0001);
    wr(A_COUNT, 2'b11, 16'h0000);
    rd(A_COUNT, d, ds); chk("count_ro", d, 16'h0003);
    wr(A_CAUSE, 2'b01, 16'h0001);
    rd(A_CAUSE, d, ds); chk("cleared_cause", d, 16'h0000);
    chk("cleared_valid", cause_valid, 0);
    // saturation on the HOLD=1 / QUIET=0 instance
    pc = 16'h0000;
    force dut_s.count_d = 16'hFFFD;
    tick();
    release dut_s.count_d;
    rd(A_COUNT, d, ds); chk("sat_preload", ds, 16'hFFFD);
    s_viol = 7'h01;
    highs = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (s_rst) highs++;
    end
    s_viol = 7'h00;
    chk("q0_pulses", highs, 4);
    tick();
    rd(A_COUNT, d, ds); chk("sat_count", ds, 16'hFFFF);
    rd(A_CAUSE, d, ds); chk("sat_cause", ds, 16'h0001);
    rd(14'h00CA, d, ds); chk("unmapped_hi", ds, 16'h0000);
    rd(14'h00C7, d, ds); chk("unmapped_lo", ds, 16'h0000);
    // reset mid-HOLD
    do_reset();
    viol = 7'h01;
    tick();
    viol = 7'h00;
    run(3, highs);
    chk("mid_hold_rst_hi", cpu_rst, 1);
    rd(A_COUNT, d, ds); chk("mid_hold_count", d, 16'h0001);
    reset_n = 1'b0;
    tick();
    chk("rst_hold_cpu_rst", cpu_rst, 0);
    chk("rst_hold_valid", cause_valid, 0);
    chk("rst_hold_state", dut.state_q, IDLE);
    rd(A_CAUSE, d, ds); chk("rst_hold_cause", d, 16'h0000);
    rd(A_COUNT, d, ds); chk("rst_hold_count", d, 16'h0000);
    reset_n = 1'b1;
    tick();
    chk("rst_hold_stays_low", cpu_rst, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
